ex_stage: RTL and testbench

//  Execute stage of the RV32 in-order pipeline. Consumes the ID/EX operand bundle, resolves operand

---
 rtl/ex_pkg.sv | 32 +++
 rtl/ex_if.sv | 49 ++++
 rtl/alu.sv | 32 +++
 rtl/ex_forward.sv | 36 +++
 rtl/ex_stage.sv | 114 +++++++++++
 tb/tb_ex_stage.sv | 189 ++++++++++++++++++
 6 files changed

// File: rtl/ex_pkg.sv
// Shared types and constants for the RV32 execute stage.
//   XLEN, REG_ADDR_W : datapath and register-index widths
//   op1_sel_t        : first ALU operand source (RS1 / PC / ZERO)
//   op2_sel_t        : second ALU operand source (RS2 / IMM / FOUR)
//   ALU_*            : ALU operation codes (funct3-aligned)
package ex_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    OP1_RS1  = 2'd0,
    OP1_PC   = 2'd1,
    OP1_ZERO = 2'd2
  } op1_sel_t;

  typedef enum logic [1:0] {
    OP2_RS2  = 2'd0,
    OP2_IMM  = 2'd1,
    OP2_FOUR = 2'd2
  } op2_sel_t;

  localparam logic [2:0] ALU_ADD  = 3'd0; // switch: 1=add 0=sub
  localparam logic [2:0] ALU_SLL  = 3'd1;
  localparam logic [2:0] ALU_SLT  = 3'd2;
  localparam logic [2:0] ALU_SLTU = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_SRX  = 3'd5; // switch: 1=logical 0=arithmetic
  localparam logic [2:0] ALU_OR   = 3'd6;
  localparam logic [2:0] ALU_AND  = 3'd7;

endpackage

// File: rtl/ex_if.sv
// Bus bundle around the execute stage: ID/EX operand bundle with valid/ready,
// writeback forwarding source, flush, and the EX/MEM register outputs with
// valid/ready.
//   slave  : the execute stage itself
//   master : the surrounding pipeline (decode, writeback, memory stage)
interface ex_if
  import ex_pkg::*;
  ();

  logic                  id_valid;
  logic                  id_ready;
  logic [XLEN-1:0]       id_pc;
  logic [REG_ADDR_W-1:0] id_rs1_idx;
  logic [REG_ADDR_W-1:0] id_rs2_idx;
  logic [XLEN-1:0]       id_rs1_val;
  logic [XLEN-1:0]       id_rs2_val;
  logic [XLEN-1:0]       id_imm;
  logic [1:0]            id_op1_sel;
  logic [1:0]            id_op2_sel;
  logic [2:0]            id_alu_ctrl;
  logic                  id_alu_switch;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_rd_we;
  logic                  flush;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic                  wb_rd_we;
  logic [XLEN-1:0]       wb_data;
  logic                  ex_valid;
  logic                  ex_ready;
  logic [XLEN-1:0]       ex_result;
  logic [XLEN-1:0]       ex_store_data;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_rd_we;

  modport slave (
    input  id_valid, id_pc, id_rs1_idx, id_rs2_idx, id_rs1_val, id_rs2_val,
           id_imm, id_op1_sel, id_op2_sel, id_alu_ctrl, id_alu_switch,
           id_rd, id_rd_we, flush, wb_rd, wb_rd_we, wb_data, ex_ready,
    output id_ready, ex_valid, ex_result, ex_store_data, ex_rd, ex_rd_we
  );

  modport master (
    output id_valid, id_pc, id_rs1_idx, id_rs2_idx, id_rs1_val, id_rs2_val,
           id_imm, id_op1_sel, id_op2_sel, id_alu_ctrl, id_alu_switch,
           id_rd, id_rd_we, flush, wb_rd, wb_rd_we, wb_data, ex_ready,
    input  id_ready, ex_valid, ex_result, ex_store_data, ex_rd, ex_rd_we
  );

endinterface

// File: rtl/alu.sv
// 32-bit integer ALU, purely combinational, wrap-around arithmetic.
//   a, b       : operands
//   ctrl       : ALU_* operation code
//   alu_switch : ADD 1=add 0=sub; SRX 1=logical 0=arithmetic
//   result     : operation result
module alu
  import ex_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      ctrl,
  input  logic            alu_switch,
  output logic [XLEN-1:0] result
);

  // Operation decode; shifts use only the low five bits of b
  always_comb begin
    result = {XLEN{1'b0}};
    case (ctrl)
      ALU_ADD:  result = alu_switch ? (a + b) : (a - b);
      ALU_SLL:  result = a << b[4:0];
      ALU_SLT:  result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: result = (a < b) ? 32'd1 : 32'd0;
      ALU_XOR:  result = a ^ b;
      ALU_SRX:  result = alu_switch ? (a >> b[4:0]) : 32'($signed(a) >>> b[4:0]);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = {XLEN{1'b0}};
    endcase
  end

endmodule

// File: rtl/ex_forward.sv
// Combinational forwarding mux for one source operand.
//   idx       : source register index
//   reg_val   : regfile value (possibly stale)
//   ex_*      : EX/MEM register contents (highest priority source)
//   wb_*      : writeback bus (second priority source)
//   fwd_val   : resolved operand value; x0 always reads as zero
module ex_forward
  import ex_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] idx,
  input  logic [XLEN-1:0]       reg_val,
  input  logic                  ex_valid,
  input  logic                  ex_rd_we,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [XLEN-1:0]       ex_result,
  input  logic                  wb_rd_we,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  output logic [XLEN-1:0]       fwd_val
);

  // Priority select: x0, then the younger EX/MEM result, then writeback, then regfile
  always_comb begin
    fwd_val = reg_val;
    if (idx == {REG_ADDR_W{1'b0}}) begin
      fwd_val = {XLEN{1'b0}};
    end else if (ex_valid && ex_rd_we && (ex_rd == idx)) begin
      fwd_val = ex_result;
    end else if (wb_rd_we && (wb_rd == idx)) begin
      fwd_val = wb_data;
    end else begin
      fwd_val = reg_val;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage of the RV32 in-order pipeline. Resolves operand forwarding,
// selects ALU operands, and registers result, store data and destination
// into the EX/MEM register under valid/ready flow control.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : ex_if.slave (ID/EX bundle, writeback bus, flush, EX/MEM outputs)
module ex_stage
  import ex_pkg::*;
(
  input  logic clk,
  input  logic rst,
  ex_if.slave  bus
);

  logic                  ex_valid_q,      ex_valid_d;
  logic [XLEN-1:0]       ex_result_q,     ex_result_d;
  logic [XLEN-1:0]       ex_store_data_q, ex_store_data_d;
  logic [REG_ADDR_W-1:0] ex_rd_q,         ex_rd_d;
  logic                  ex_rd_we_q,      ex_rd_we_d;

  logic            id_ready_s;
  logic            capture_s;
  logic [XLEN-1:0] rs1_fwd_s, rs2_fwd_s, op1_s, op2_s, alu_result_s;

  ex_forward u_fwd_rs1 (
    .idx(bus.id_rs1_idx), .reg_val(bus.id_rs1_val),
    .ex_valid(ex_valid_q), .ex_rd_we(ex_rd_we_q), .ex_rd(ex_rd_q), .ex_result(ex_result_q),
    .wb_rd_we(bus.wb_rd_we), .wb_rd(bus.wb_rd), .wb_data(bus.wb_data),
    .fwd_val(rs1_fwd_s)
  );

  ex_forward u_fwd_rs2 (
    .idx(bus.id_rs2_idx), .reg_val(bus.id_rs2_val),
    .ex_valid(ex_valid_q), .ex_rd_we(ex_rd_we_q), .ex_rd(ex_rd_q), .ex_result(ex_result_q),
    .wb_rd_we(bus.wb_rd_we), .wb_rd(bus.wb_rd), .wb_data(bus.wb_data),
    .fwd_val(rs2_fwd_s)
  );

  // Operand selection; reserved encodings feed zero
  always_comb begin
    op1_s = {XLEN{1'b0}};
    op2_s = {XLEN{1'b0}};
    case (bus.id_op1_sel)
      OP1_RS1:  op1_s = rs1_fwd_s;
      OP1_PC:   op1_s = bus.id_pc;
      OP1_ZERO: op1_s = {XLEN{1'b0}};
      default:  op1_s = {XLEN{1'b0}};
    endcase
    case (bus.id_op2_sel)
      OP2_RS2:  op2_s = rs2_fwd_s;
      OP2_IMM:  op2_s = bus.id_imm;
      OP2_FOUR: op2_s = 32'd4;
      default:  op2_s = {XLEN{1'b0}};
    endcase
  end

  alu u_alu (
    .a(op1_s), .b(op2_s), .ctrl(bus.id_alu_ctrl), .alu_switch(bus.id_alu_switch),
    .result(alu_result_s)
  );

  assign id_ready_s = !ex_valid_q || bus.ex_ready;
  assign capture_s  = bus.id_valid && id_ready_s && !bus.flush;

  // EX/MEM next state: flush > capture > drain > hold. rd_we is cleared
  // whenever the entry empties so the registered output is already qualified.
  always_comb begin
    ex_valid_d      = ex_valid_q;
    ex_result_d     = ex_result_q;
    ex_store_data_d = ex_store_data_q;
    ex_rd_d         = ex_rd_q;
    ex_rd_we_d      = ex_rd_we_q;
    if (bus.flush) begin
      ex_valid_d = 1'b0;
      ex_rd_we_d = 1'b0;
    end else if (capture_s) begin
      ex_valid_d      = 1'b1;
      ex_result_d     = alu_result_s;
      ex_store_data_d = rs2_fwd_s;
      ex_rd_d         = bus.id_rd;
      ex_rd_we_d      = bus.id_rd_we;
    end else if (ex_valid_q && bus.ex_ready) begin
      ex_valid_d = 1'b0;
      ex_rd_we_d = 1'b0;
    end else begin
      ex_valid_d = ex_valid_q;
    end
  end

  // EX/MEM register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q      <= 1'b0;
      ex_result_q     <= {XLEN{1'b0}};
      ex_store_data_q <= {XLEN{1'b0}};
      ex_rd_q         <= {REG_ADDR_W{1'b0}};
      ex_rd_we_q      <= 1'b0;
    end else begin
      ex_valid_q      <= ex_valid_d;
      ex_result_q     <= ex_result_d;
      ex_store_data_q <= ex_store_data_d;
      ex_rd_q         <= ex_rd_d;
      ex_rd_we_q      <= ex_rd_we_d;
    end
  end

  assign bus.id_ready      = id_ready_s;
  assign bus.ex_valid      = ex_valid_q;
  assign bus.ex_result     = ex_result_q;
  assign bus.ex_store_data = ex_store_data_q;
  assign bus.ex_rd         = ex_rd_q;
  assign bus.ex_rd_we      = ex_rd_we_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: the driver pushes the hand-computed
// EX/MEM contents of every captured bundle; a monitor pops and compares on
// each EX/MEM handshake. Stall, flush and reset are checked directly.
module tb_ex_stage;
  import ex_pkg::*;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] st;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  logic clk;
  logic rst;
  ex_if bus ();

  ex_stage dut (.clk(clk), .rst(rst), .bus(bus));

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compare each EX/MEM transfer against the oldest expectation
  always @(negedge clk) begin
    if (!rst && bus.ex_valid === 1'b1 && bus.ex_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output result=0x%08h rd=%0d", bus.ex_result, bus.ex_rd);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mon_result", bus.ex_result, e.res);
        chk("mon_store", bus.ex_store_data, e.st);
        chk("mon_rd", 32'(bus.ex_rd), 32'(e.rd));
        chk("mon_rd_we", 32'(bus.ex_rd_we), 32'(e.we));
      end
    end
  end

  task automatic set_bundle(input logic [31:0] pc, input logic [4:0] rs1i, input logic [31:0] rs1v,
                            input logic [4:0] rs2i, input logic [31:0] rs2v, input logic [31:0] imm,
                            input logic [1:0] s1, input logic [1:0] s2, input logic [2:0] ctrl,
                            input logic sw, input logic [4:0] rd, input logic we);
    bus.id_pc = pc; bus.id_rs1_idx = rs1i; bus.id_rs1_val = rs1v;
    bus.id_rs2_idx = rs2i; bus.id_rs2_val = rs2v; bus.id_imm = imm;
    bus.id_op1_sel = s1; bus.id_op2_sel = s2; bus.id_alu_ctrl = ctrl;
    bus.id_alu_switch = sw; bus.id_rd = rd; bus.id_rd_we = we;
  endtask

  // Present one bundle for one cycle (called at posedge+1); push expectation if it will capture
  task automatic issue(input logic [31:0] pc, input logic [4:0] rs1i, input logic [31:0] rs1v,
                       input logic [4:0] rs2i, input logic [31:0] rs2v, input logic [31:0] imm,
                       input logic [1:0] s1, input logic [1:0] s2, input logic [2:0] ctrl,
                       input logic sw, input logic [4:0] rd, input logic we,
                       input logic [31:0] eres, input logic [31:0] est);
    exp_t e;
    set_bundle(pc, rs1i, rs1v, rs2i, rs2v, imm, s1, s2, ctrl, sw, rd, we);
    bus.id_valid = 1'b1;
    if (bus.id_ready && !bus.flush) begin
      e.res = eres; e.st = est; e.rd = rd; e.we = we;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    bus.id_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.id_valid = 1'b0; bus.flush = 1'b0; bus.ex_ready = 1'b1;
    bus.wb_rd = 5'd0; bus.wb_rd_we = 1'b0; bus.wb_data = 32'd0;
    set_bundle(32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 2'd0, 2'd0, 3'd0, 1'b0, 5'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("rst_ex_result", bus.ex_result, 32'd0);
    chk("rst_ex_rd_we", 32'(bus.ex_rd_we), 32'd0);
    chk("rst_id_ready", 32'(bus.id_ready), 32'd1);
    @(posedge clk); #1;

    // pc rs1i rs1v rs2i rs2v imm s1 s2 ctrl sw rd we | result store
    issue(32'h0, 5'd1, 32'd5, 5'd2, 32'h11, 32'd7, OP1_RS1, OP2_IMM, ALU_ADD, 1'b1, 5'd3, 1'b1, 32'd12, 32'h11);
    // EX/MEM forward of rd=3 (12) into a SUB
    issue(32'h0, 5'd3, 32'd0, 5'd8, 32'd2, 32'd0, OP1_RS1, OP2_RS2, ALU_ADD, 1'b0, 5'd6, 1'b1, 32'd10, 32'd2);
    // store data forwarded from rd=6 even with op2=IMM; writes x0
    issue(32'h0, 5'd0, 32'd0, 5'd6, 32'd0, 32'd99, OP1_ZERO, OP2_IMM, ALU_ADD, 1'b1, 5'd0, 1'b1, 32'd99, 32'd10);
    // x0 never forwarded from EX/MEM or WB, and reads zero despite stale regfile value
    bus.wb_rd = 5'd0; bus.wb_rd_we = 1'b1; bus.wb_data = 32'd55;
    issue(32'h0, 5'd0, 32'd0, 5'd0, 32'h1234, 32'd1, OP1_RS1, OP2_IMM, ALU_ADD, 1'b1, 5'd5, 1'b1, 32'd1, 32'd0);
    bus.wb_rd_we = 1'b0;
    issue(32'h0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd12, OP1_ZERO, OP2_IMM, ALU_ADD, 1'b1, 5'd4, 1'b1, 32'd12, 32'd0);
    // EX/MEM (12) beats WB (77) for rd=4
    bus.wb_rd = 5'd4; bus.wb_rd_we = 1'b1; bus.wb_data = 32'd77;
    issue(32'h0, 5'd4, 32'd3, 5'd4, 32'd3, 32'd0, OP1_RS1, OP2_FOUR, ALU_ADD, 1'b1, 5'd7, 1'b1, 32'd16, 32'd12);
    // PC + 4, store data forwarded from WB only
    bus.wb_rd = 5'd9;
    issue(32'h100, 5'd4, 32'd0, 5'd9, 32'd1, 32'd0, OP1_PC, OP2_FOUR, ALU_ADD, 1'b1, 5'd1, 1'b1, 32'h104, 32'd77);
    bus.wb_rd_we = 1'b0;
    // reserved selects yield zero operands
    issue(32'h0, 5'd10, 32'd50, 5'd0, 32'd0, 32'd9, 2'd3, 2'd3, ALU_ADD, 1'b1, 5'd8, 1'b1, 32'd0, 32'd0);
    issue(32'h0, 5'd10, 32'h80000000, 5'd0, 32'd0, 32'd4, OP1_RS1, OP2_IMM, ALU_SRX, 1'b0, 5'd9, 1'b1, 32'hF8000000, 32'd0);
    issue(32'h0, 5'd10, 32'h80000000, 5'd0, 32'd0, 32'd4, OP1_RS1, OP2_IMM, ALU_SRX, 1'b1, 5'd11, 1'b1, 32'h08000000, 32'd0);
    issue(32'h0, 5'd12, 32'hFFFFFFFF, 5'd0, 32'd0, 32'd1, OP1_RS1, OP2_IMM, ALU_SLT, 1'b0, 5'd13, 1'b1, 32'd1, 32'd0);
    issue(32'h0, 5'd12, 32'hFFFFFFFF, 5'd0, 32'd0, 32'd1, OP1_RS1, OP2_IMM, ALU_SLTU, 1'b0, 5'd14, 1'b1, 32'd0, 32'd0);
    // wrap-around add, no write enable
    issue(32'h0, 5'd12, 32'hFFFFFFFF, 5'd0, 32'd0, 32'd1, OP1_RS1, OP2_IMM, ALU_ADD, 1'b1, 5'd15, 1'b0, 32'd0, 32'd0);
    // rd=15 had we=0, so regfile value is used
    issue(32'h0, 5'd15, 32'hF0F0F0F0, 5'd0, 32'd0, 32'h0FF00FF0, OP1_RS1, OP2_IMM, ALU_XOR, 1'b0, 5'd16, 1'b1, 32'hFF00FF00, 32'd0);
    drain("drain_main");

    // Stall: hold for three cycles while a new bundle waits, then flush
    bus.ex_ready = 1'b0;
    issue(32'h0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd5, OP1_ZERO, OP2_IMM, ALU_ADD, 1'b1, 5'd2, 1'b1, 32'd5, 32'd0);
    set_bundle(32'h0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd66, OP1_ZERO, OP2_IMM, ALU_ADD, 1'b1, 5'd17, 1'b1);
    bus.id_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_id_ready", 32'(bus.id_ready), 32'd0);
      chk("stall_ex_valid", 32'(bus.ex_valid), 32'd1);
      chk("stall_ex_result", bus.ex_result, 32'd5);
      chk("stall_ex_rd", 32'(bus.ex_rd), 32'd2);
      chk("stall_ex_rd_we", 32'(bus.ex_rd_we), 32'd1);
      @(posedge clk); #1;
    end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.id_valid = 1'b0;
    void'(exp_q.pop_front());
    @(negedge clk);
    chk("flush_ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("flush_ex_rd_we", 32'(bus.ex_rd_we), 32'd0);
    chk("flush_id_ready", 32'(bus.id_ready), 32'd1);
    @(posedge clk); #1;
    bus.ex_ready = 1'b1;
    @(posedge clk); #1;

    // Reset while stalled drops the entry
    bus.ex_ready = 1'b0;
    issue(32'h0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd33, OP1_ZERO, OP2_IMM, ALU_ADD, 1'b1, 5'd20, 1'b1, 32'd33, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(exp_q.pop_front());
    @(negedge clk);
    chk("rst2_ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("rst2_ex_result", bus.ex_result, 32'd0);
    chk("rst2_ex_store", bus.ex_store_data, 32'd0);
    chk("rst2_ex_rd", 32'(bus.ex_rd), 32'd0);
    chk("rst2_ex_rd_we", 32'(bus.ex_rd_we), 32'd0);
    chk("rst2_id_ready", 32'(bus.id_ready), 32'd1);
    @(posedge clk); #1;
    bus.ex_ready = 1'b1;

    // Normal operation resumes after reset
    issue(32'h0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd7, OP1_ZERO, OP2_IMM, ALU_ADD, 1'b1, 5'd3, 1'b1, 32'd7, 32'd0);
    drain("drain_final");
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
